// File: rtl/out_serializer_if.sv
// Interface bundling the flattened-word input strobe and the beat stream
// toward the MAC/TX side. The stats counters exist only when
// OUT_SER_STATS_EN is defined.
interface out_serializer_if #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned BEAT_W = 64
);
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_en;
  logic [BEAT_W-1:0] io_out_data;
  logic              io_out_valid;
  logic              io_out_ready;
  logic              io_out_last;
  logic              io_full;
`ifdef OUT_SER_STATS_EN
  logic [31:0]       io_drop_cnt;
  logic [31:0]       io_pkt_cnt;

  modport master (
    output io_in_data, io_in_en, io_out_ready,
    input  io_out_data, io_out_valid, io_out_last, io_full,
    input  io_drop_cnt, io_pkt_cnt
  );
  modport slave (
    input  io_in_data, io_in_en, io_out_ready,
    output io_out_data, io_out_valid, io_out_last, io_full,
    output io_drop_cnt, io_pkt_cnt
  );
`else
  modport master (
    output io_in_data, io_in_en, io_out_ready,
    input  io_out_data, io_out_valid, io_out_last, io_full
  );
  modport slave (
    input  io_in_data, io_in_en, io_out_ready,
    output io_out_data, io_out_valid, io_out_last, io_full
  );
`endif
endinterface

// File: rtl/out_serializer.sv
// out_serializer: buffers whole flattened PHV words in a DEPTH-entry FIFO and
// streams each word out as NBEATS beats of BEAT_W bits (beat 0 = low bits).
// Words arriving while the FIFO is full are dropped (unless the last beat of
// the head word leaves in the same cycle).
// Optional feature macro: OUT_SER_STATS_EN (drop / packet counters).
module out_serializer #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic            clock,
  input  logic            reset,
  out_serializer_if.slave io
);
  localparam int unsigned NBEATS = DATA_W / BEAT_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BI_W   = $clog2(NBEATS);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic [DATA_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BI_W-1:0]   beat_idx_q, beat_idx_d;
  state_t            state_q, state_d;

  logic valid, last, beat_fire, pop, push, full;
  logic [NBEATS-1:0][BEAT_W-1:0] rd_word;

  // Handshake qualifiers, all derived from registered state plus inputs
  always_comb begin
    valid     = (state_q == SEND);
    last      = valid && (beat_idx_q == BI_W'(NBEATS - 1));
    full      = (count_q == CNT_W'(DEPTH));
    beat_fire = valid && io.io_out_ready;
    pop       = beat_fire && last;
    push      = io.io_in_en && (!full || pop);
  end

  // Read mux: the head word viewed as an array of beats; zero when idle
  always_comb begin
    rd_word        = fifo_q[rd_ptr_q];
    io.io_out_data = valid ? rd_word[beat_idx_q] : '0;
  end

  assign io.io_out_valid = valid;
  assign io.io_out_last  = last;
  assign io.io_full      = full;

  // Next-state for FIFO storage, pointers, occupancy, beat index and FSM
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_idx_d = beat_idx_q;
    if (push) begin
      fifo_d[wr_ptr_q] = io.io_in_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (beat_fire) begin
      if (last) begin
        beat_idx_d = '0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end else begin
        beat_idx_d = beat_idx_q + BI_W'(1);
      end
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // SEND whenever the next occupancy is non-zero, so valid follows count
    // one register stage later with no path from the inputs
    state_d = (count_d != '0) ? SEND : IDLE;
  end

  // Control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_idx_q <= '0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_idx_q <= beat_idx_d;
      state_q    <= state_d;
    end
  end

  // Word storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

`ifdef OUT_SER_STATS_EN
  logic        drop;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  // Drop counter saturates; packet counter wraps
  always_comb begin
    drop       = io.io_in_en && full && !pop;
    drop_cnt_d = drop_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
    if (pop) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  // Stats registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign io.io_drop_cnt = drop_cnt_q;
  assign io.io_pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_out_serializer.sv
// Scoreboard bench for out_serializer: a queue-level model predicts which
// words are accepted and the beats each produces; a negedge monitor checks
// every fired beat plus valid/full/last and the optional stats counters.
module tb_out_serializer;
  localparam int unsigned DW = 1024;
  localparam int unsigned BW = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB = DW / BW;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_serializer_if #(.DATA_W(DW), .BEAT_W(BW)) bus ();

  out_serializer #(.DATA_W(DW), .BEAT_W(BW), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state: words held, current beat of head word, stats
  logic [DW-1:0] mq[$];
  beat_t         expq[$];
  int            mb = 0;
  logic [31:0]   mdrop = 0;
  logic [31:0]   mpkt = 0;
  bit            m_v, m_fire, m_last, m_full;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is accepted if there is room or the head word's
  // last beat leaves on the same edge; accepted words become NB beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      expq.delete();
      mb = 0;
      mdrop = 0;
      mpkt = 0;
    end else begin
      m_v    = (mq.size() != 0);
      m_fire = m_v && bus.io_out_ready;
      m_last = m_fire && (mb == NB - 1);
      m_full = (mq.size() == DEPTH);
      if (m_fire) begin
        if (m_last) begin
          void'(mq.pop_front());
          mb = 0;
          mpkt = mpkt + 1;
        end else begin
          mb = mb + 1;
        end
      end
      if (bus.io_in_en) begin
        if (!m_full || m_last) begin
          mq.push_back(bus.io_in_data);
          for (int b = 0; b < NB; b++) begin
            beat_t e;
            e.d = bus.io_in_data[b*BW +: BW];
            e.l = (b == NB - 1);
            expq.push_back(e);
          end
        end else if (mdrop != 32'hFFFF_FFFF) begin
          mdrop = mdrop + 1;
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle; pop expected beat on every fire
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", BW'(bus.io_out_valid), BW'(mq.size() != 0));
      chk("full", BW'(bus.io_full), BW'(mq.size() == DEPTH));
      chk("last", BW'(bus.io_out_last), BW'((mq.size() != 0) && (mb == NB - 1)));
`ifdef OUT_SER_STATS_EN
      chk("drop_cnt", BW'(bus.io_drop_cnt), BW'(mdrop));
      chk("pkt_cnt", BW'(bus.io_pkt_cnt), BW'(mpkt));
`endif
      if (bus.io_out_valid && bus.io_out_ready) begin
        if (expq.size() == 0) begin
          chk("beat_unexpected", BW'(1), BW'(0));
        end else begin
          beat_t e;
          e = expq.pop_front();
          chk("beat_data", bus.io_out_data, e.d);
          chk("beat_last", BW'(bus.io_out_last), BW'(e.l));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] ramp_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 8; k++) w[k*8 +: 8] = 8'(k);
    return w;
  endfunction

  task automatic send(input logic [DW-1:0] w);
    bus.io_in_data = w;
    bus.io_in_en   = 1'b1;
    tick();
    bus.io_in_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    bus.io_out_ready = 1'b1;
    for (i = 0; i < 3000 && (expq.size() != 0 || mq.size() != 0); i++) tick();
    chk(name, BW'(expq.size()), BW'(0));
    tick();
  endtask

  initial begin
    bus.io_in_data   = '0;
    bus.io_in_en     = 1'b0;
    bus.io_out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", BW'(bus.io_out_valid), BW'(0));
    chk("rst_last", BW'(bus.io_out_last), BW'(0));
    chk("rst_full", BW'(bus.io_full), BW'(0));
    chk("rst_data", bus.io_out_data, BW'(0));
    rst = 1'b0;
    tick();

    // 1: ramp word, ready held high
    bus.io_out_ready = 1'b1;
    send(ramp_word());
    chk("t1_beat0", bus.io_out_data, 64'h0706050403020100);
    drain("t1_drain");

    // 2: ramp word, ready toggling every cycle
    send(ramp_word());
    for (int i = 0; i < 40; i++) begin
      bus.io_out_ready = ~bus.io_out_ready;
      tick();
    end
    drain("t2_drain");

    // 3: five words while stalled; fifth is dropped
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_word());
    chk("t3_full", BW'(bus.io_full), BW'(1));
    drain("t3_drain");

    // 4: new word coincides with the head word's last-beat fire while full
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_word());
    bus.io_out_ready = 1'b1;
    repeat (NB - 1) tick();
    send(rand_word());
    chk("t4_full_kept", BW'(bus.io_full), BW'(1));
    drain("t4_drain");

    // 5: reset during beat 7 with further words queued
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_word());
    bus.io_out_ready = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("t5_valid_drop", BW'(bus.io_out_valid), BW'(0));
    chk("t5_last_drop", BW'(bus.io_out_last), BW'(0));
    chk("t5_data_zero", bus.io_out_data, BW'(0));
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t5_empty", BW'(bus.io_full | bus.io_out_valid), BW'(0));
    send(ramp_word());
    chk("t5_beat0", bus.io_out_data, 64'h0706050403020100);
    drain("t5_drain");

    // 6: random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.io_in_en     = ($urandom_range(0, 99) < 35);
      bus.io_in_data   = rand_word();
      bus.io_out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    bus.io_in_en = 1'b0;
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
